// File: rtl/memory_port_arbiter.sv
// Purpose: shares one single-port data memory between the CPU load/store port and the image loader.
// Latency: request seen in IDLE at t -> mem_en at t+1 -> ack at t+2; one access per 3 cycles.
// Backpressure: requesters hold req until a one-cycle ack; the CPU stalls on cpu_stall meanwhile.
// Optional feature macro ARB_STATS_EN: per-port grant counters plus a synchronous stats_clr.
module memory_port_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic              ldr_lock,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
`ifdef ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [15:0]       cpu_grant_cnt,
   output logic [15:0]       ldr_grant_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
   typedef enum logic {OWN_CPU, OWN_LDR} owner_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   state_t            state, state_nxt;
   owner_t            owner, last_owner, grant_port;
   logic              grant_vld;
   logic [3:0]        burst_cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;

   // Winner selection: round-robin on a tie, loader may keep ownership under lock until the burst limit
   always_comb begin
      grant_port = OWN_CPU;
      if (cpu_req && ldr_req) begin
         if (last_owner == OWN_CPU) begin
            grant_port = OWN_LDR;
         end else if (ldr_lock && (burst_cnt < BURST_MAX)) begin
            grant_port = OWN_LDR;
         end
      end else if (ldr_req) begin
         grant_port = OWN_LDR;
      end
   end

   // Next-state and access outputs; memory bus is all-zero outside ISSUE
   always_comb begin
      state_nxt = state;
      grant_vld = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_ack   = 1'b0;
      ldr_ack   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cpu_req || ldr_req) begin
               grant_vld = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            cpu_ack   = (owner == OWN_CPU);
            ldr_ack   = (owner == OWN_LDR);
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the winning request so the access completes even if req drops mid-flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= OWN_CPU;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant_vld) begin
         owner     <= grant_port;
         lat_we    <= (grant_port == OWN_LDR) ? ldr_we    : cpu_we;
         lat_addr  <= (grant_port == OWN_LDR) ? ldr_addr  : cpu_addr;
         lat_wdata <= (grant_port == OWN_LDR) ? ldr_wdata : cpu_wdata;
      end
   end

   // Fairness bookkeeping: last owner and the loader burst counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner <= OWN_LDR;
         burst_cnt  <= '0;
      end else begin
         if (state == S_DONE) begin
            last_owner <= owner;
         end
         if (state == S_IDLE) begin
            if (!ldr_lock) begin
               burst_cnt <= '0;
            end else if (grant_vld) begin
               if (grant_port == OWN_CPU) begin
                  burst_cnt <= '0;
               end else if (cpu_req && (burst_cnt < BURST_MAX)) begin
                  burst_cnt <= burst_cnt + 4'd1;
               end
            end
         end
      end
   end

   // Hold the last read word per port until that port's next read completes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else if ((state == S_DONE) && !lat_we) begin
         if (owner == OWN_CPU) begin
            cpu_rdata_q <= mem_rdata;
         end else begin
            ldr_rdata_q <= mem_rdata;
         end
      end
   end

   // Read data is forwarded straight from memory during the ack cycle, then held
   always_comb begin
      cpu_rdata = (cpu_ack && !lat_we) ? mem_rdata : cpu_rdata_q;
      ldr_rdata = (ldr_ack && !lat_we) ? mem_rdata : ldr_rdata_q;
      cpu_stall = cpu_req & ~cpu_ack;
      busy      = (state != S_IDLE);
   end

`ifdef ARB_STATS_EN
   // Grant counters bump on entry to ISSUE; a clear in the same cycle wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_grant_cnt <= '0;
         ldr_grant_cnt <= '0;
      end else if (stats_clr) begin
         cpu_grant_cnt <= '0;
         ldr_grant_cnt <= '0;
      end else if (grant_vld) begin
         if (grant_port == OWN_CPU) begin
            cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
         end else begin
            ldr_grant_cnt <= ldr_grant_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed cases plus randomized traffic against a scoreboard.
// Stimulus and reference model run at negedge; a separate monitor checks outputs 1ns after posedge.
// Requesters follow the hold-until-ack protocol as predicted by the reference model.
`timescale 1ns/1ps
module tb_memory_port_arbiter;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 4;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;
   typedef struct {
      int                cyc;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_exp_t;
   typedef struct {
      int                cyc;
      logic              port;
      logic [DATA_W-1:0] rdata;
   } ack_exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0, ldr_addr = '0, mem_addr;
   logic [DATA_W-1:0] cpu_wdata = '0, ldr_wdata = '0, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
   logic              cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we, busy;
`ifdef ARB_STATS_EN
   logic              stats_clr = 1'b0;
   logic [15:0]       cpu_grant_cnt, ldr_grant_cnt;
   bit                clr_on_grant = 1'b0;
`endif

   always #5 clk = ~clk;

   memory_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
      .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
      , .stats_clr(stats_clr), .cpu_grant_cnt(cpu_grant_cnt), .ldr_grant_cnt(ldr_grant_cnt)
`endif
   );

   // ---------------- memory environment ----------------
   logic [DATA_W-1:0] mem_arr [256];
   logic [DATA_W-1:0] ref_mem [256];
   logic              fill_en = 1'b0, poke_en = 1'b0;
   logic [31:0]       fill_seed = '0;
   logic [7:0]        poke_addr = '0;
   logic [31:0]       poke_dat = '0;

   function automatic logic [31:0] init_word(input int a, input logic [31:0] seed);
      return (32'(a) * 32'h9E3779B1) ^ seed;
   endfunction

   // Synchronous-read memory behind the arbiter
   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i, fill_seed);
      end else if (poke_en) begin
         mem_arr[poke_addr] <= poke_dat;
      end else if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int       n_checks = 0;
   int       n_fail = 0;
   bit       mon_en = 1'b0;
   mem_exp_t exp_mem[$];
   ack_exp_t exp_ack[$];
   int       ack_log[$];
   int       exp_order[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic note_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got nothing expected an event (cycle %0d)", nm, cyc);
   endtask

   // Monitor: compares every cycle against what the model queued
   initial begin
      mem_exp_t me;
      ack_exp_t ae;
      bit       in_issue, in_done, cpu_done_now;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            while (exp_mem.size() > 0 && exp_mem[0].cyc < cyc) begin
               note_fail("mem_access_missing");
               void'(exp_mem.pop_front());
            end
            while (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
               note_fail("ack_missing");
               void'(exp_ack.pop_front());
            end
            in_issue     = exp_mem.size() > 0 && exp_mem[0].cyc == cyc;
            in_done      = exp_ack.size() > 0 && exp_ack[0].cyc == cyc;
            cpu_done_now = in_done && (exp_ack[0].port == 1'b0);
            chk("busy", 64'(busy), 64'(in_issue || in_done));
            chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !cpu_done_now));
            if (in_issue) begin
               me = exp_mem.pop_front();
               chk("mem_en", 64'(mem_en), 64'd1);
               chk("mem_we", 64'(mem_we), 64'(me.we));
               chk("mem_addr", 64'(mem_addr), 64'(me.addr));
               chk("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
            end else begin
               chk("mem_bus_idle", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
            end
            if (cpu_ack && !ldr_ack) ack_log.push_back(0);
            if (ldr_ack && !cpu_ack) ack_log.push_back(1);
            if (in_done) begin
               ae = exp_ack.pop_front();
               chk("ack_port", 64'({cpu_ack, ldr_ack}), ae.port ? 64'd1 : 64'd2);
               if (ae.port) chk("ldr_rdata", 64'(ldr_rdata), 64'(ae.rdata));
               else         chk("cpu_rdata", 64'(cpu_rdata), 64'(ae.rdata));
            end else begin
               chk("ack_idle", 64'({cpu_ack, ldr_ack}), 64'd0);
            end
         end
      end
   end

   // ---------------- reference model and requesters ----------------
   int   m_phase = 0;          // 0 idle, 1 memory access, 2 acknowledge
   bit   m_owner = 1'b0, m_last = 1'b1, m_lock = 1'b0;
   int   m_burst = 0;
   bit   c_pend = 1'b0, l_pend = 1'b0, rand_on = 1'b0;
   req_t c_r, l_r;
   req_t cpu_script[$], ldr_script[$];
   logic [DATA_W-1:0] c_hold = '0, l_hold = '0;

   function automatic req_t mk_req(input logic we, input logic [7:0] a, input logic [31:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      return r;
   endfunction

   function automatic req_t rand_req();
      return mk_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom);
   endfunction

   task automatic model_reset();
      m_phase = 0; m_owner = 1'b0; m_last = 1'b1; m_burst = 0; m_lock = 1'b0;
      c_pend = 1'b0; l_pend = 1'b0; c_hold = '0; l_hold = '0;
      cpu_script.delete(); ldr_script.delete();
      exp_mem.delete(); exp_ack.delete(); ack_log.delete();
      cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
   endtask

   // One cycle of stimulus plus the model's decision for that cycle
   task automatic step();
      bit   win_ldr;
      req_t r;
      logic [DATA_W-1:0] d;
      @(negedge clk);
`ifdef ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      if (m_phase == 2) begin
         if (m_owner) l_pend = 1'b0;
         else         c_pend = 1'b0;
      end
      if (!c_pend) begin
         if (cpu_script.size() > 0) begin c_r = cpu_script.pop_front(); c_pend = 1'b1; end
         else if (rand_on && $urandom_range(0, 99) < 40) begin c_r = rand_req(); c_pend = 1'b1; end
      end
      if (!l_pend) begin
         if (ldr_script.size() > 0) begin l_r = ldr_script.pop_front(); l_pend = 1'b1; end
         else if (rand_on && $urandom_range(0, 99) < 45) begin l_r = rand_req(); l_pend = 1'b1; end
      end
      if (rand_on && $urandom_range(0, 19) == 0) m_lock = ~m_lock;
      cpu_req = c_pend; cpu_we = c_r.we; cpu_addr = c_r.addr; cpu_wdata = c_r.wdata;
      ldr_req = l_pend; ldr_we = l_r.we; ldr_addr = l_r.addr; ldr_wdata = l_r.wdata;
      ldr_lock = m_lock;
      if (m_phase == 0) begin
         if (c_pend || l_pend) begin
            if (c_pend && l_pend) begin
               win_ldr = (m_last == 1'b0);
               if (m_last && m_lock && m_burst < MAX_BURST) win_ldr = 1'b1;
            end else begin
               win_ldr = l_pend;
            end
            if (!win_ldr) m_burst = 0;
            else if (c_pend) m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
            if (!m_lock) m_burst = 0;
            r = win_ldr ? l_r : c_r;
            if (r.we) begin
               ref_mem[r.addr] = r.wdata;
               d = win_ldr ? l_hold : c_hold;
            end else begin
               d = ref_mem[r.addr];
               if (win_ldr) l_hold = d; else c_hold = d;
            end
            exp_mem.push_back('{cyc: cyc + 1, we: r.we, addr: r.addr, wdata: r.wdata});
            exp_ack.push_back('{cyc: cyc + 2, port: win_ldr, rdata: d});
            m_owner = win_ldr;
            m_last  = win_ldr;
`ifdef ARB_STATS_EN
            if (clr_on_grant) stats_clr = 1'b1;
`endif
            m_phase = 1;
         end else if (!m_lock) begin
            m_burst = 0;
         end
      end else begin
         m_phase = (m_phase == 1) ? 2 : 0;
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!(cpu_script.size() == 0 && ldr_script.size() == 0 && !c_pend && !l_pend && m_phase == 0)
             && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) note_fail("wait_idle_timeout");
      step();
      step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b0;
      model_reset();
      fill_seed = $urandom;
      fill_en = 1'b1;
      @(negedge clk);
      fill_en = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i, fill_seed);
      chk("rst_acks", 64'({cpu_ack, ldr_ack}), 64'd0);
      chk("rst_mem_bus", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      chk("rst_ldr_rdata", 64'(ldr_rdata), 64'd0);
      chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
`ifdef ARB_STATS_EN
      chk("rst_grant_cnts", 64'({cpu_grant_cnt, ldr_grant_cnt}), 64'd0);
`endif
      rst = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_dat = d;
      @(negedge clk);
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic chk_order(input string nm);
      chk({nm, "_len"}, 64'(ack_log.size()), 64'(exp_order.size()));
      for (int i = 0; i < exp_order.size() && i < ack_log.size(); i++)
         chk(nm, 64'(ack_log[i]), 64'(exp_order[i]));
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no completion expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      // CPU-only read of a known word
      do_reset();
      poke(8'h10, 32'hDEADBEEF);
      cpu_script.push_back(mk_req(1'b0, 8'h10, 32'h0));
      wait_idle(40);
      chk("cpu_read_deadbeef", 64'(cpu_rdata), 64'h00000000DEADBEEF);

      // Loader write followed by CPU read-back
      ldr_script.push_back(mk_req(1'b1, 8'h20, 32'h00A5A5A5));
      wait_idle(40);
      cpu_script.push_back(mk_req(1'b0, 8'h20, 32'h0));
      wait_idle(40);
      chk("cpu_readback_a5", 64'(cpu_rdata), 64'h0000000000A5A5A5);

      // Simultaneous requests without lock alternate, CPU first
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cpu_script.push_back(rand_req());
         ldr_script.push_back(mk_req(1'b1, 8'($urandom_range(0, 31)), $urandom));
      end
      wait_idle(60);
      exp_order = '{0, 1, 0, 1, 0, 1};
      chk_order("rr_order");

      // Locked loader bursts bounded at MAX_BURST
      do_reset();
      m_lock = 1'b1;
      for (int i = 0; i < 2; i++) cpu_script.push_back(rand_req());
      for (int i = 0; i < 8; i++) ldr_script.push_back(rand_req());
      wait_idle(100);
      exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      chk_order("lock_order");

      // Reset pulsed during the acknowledge cycle of a CPU read
      do_reset();
      cpu_script.push_back(rand_req());
      cpu_script[0].we = 1'b0;
      for (int n = 0; n < 10 && m_phase != 2; n++) step();
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_done_acks", 64'({cpu_ack, ldr_ack}), 64'd0);
      chk("rst_done_mem_bus", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
      chk("rst_done_busy", 64'(busy), 64'd0);
      chk("rst_done_cpu_rdata", 64'(cpu_rdata), 64'd0);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
      mon_en = 1'b1;
      cpu_script.push_back(rand_req());
      ldr_script.push_back(rand_req());
      wait_idle(40);
      exp_order = '{0, 1};
      chk_order("post_rst_order");

`ifdef ARB_STATS_EN
      // Grant counters and clear priority
      do_reset();
      for (int i = 0; i < 3; i++) cpu_script.push_back(rand_req());
      for (int i = 0; i < 2; i++) ldr_script.push_back(rand_req());
      wait_idle(60);
      chk("cpu_grant_cnt", 64'(cpu_grant_cnt), 64'd3);
      chk("ldr_grant_cnt", 64'(ldr_grant_cnt), 64'd2);
      clr_on_grant = 1'b1;
      cpu_script.push_back(rand_req());
      wait_idle(40);
      clr_on_grant = 1'b0;
      chk("cpu_grant_cnt_clr", 64'(cpu_grant_cnt), 64'd0);
      chk("ldr_grant_cnt_clr", 64'(ldr_grant_cnt), 64'd0);
`endif

      // Randomized traffic with lock toggling
      do_reset();
      rand_on = 1'b1;
      for (int i = 0; i < 3000; i++) step();
      rand_on = 1'b0;
      wait_idle(100);
      chk("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
      chk("exp_ack_drained", 64'(exp_ack.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 32-bit word) between two requesters: the processor's load/store port and the image loader port, which streams encrypted/decrypted pixels.
- Sequences each access through a 3-state FSM.
- Arbitrates round-robin, with an optional bounded burst lock for the loader.
- Sits between the processor/loader and the data memory; the processor stalls on cpu_stall until its access is acknowledged.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.
- MAX_BURST, 4, max consecutive loader grants under ldr_lock while cpu_req is pending (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- cpu_req  input  1  processor access request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  processor address.
- cpu_wdata  input  DATA_W  processor write data.
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack = 1.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_stall  output  1  cpu_req & ~cpu_ack (combinational).
- ldr_req  input  1  loader access request; held until ldr_ack.
- ldr_we  input  1  1 = write, 0 = read.
- ldr_lock  input  1  loader requests burst ownership.
- ldr_addr  input  ADDR_W  loader address.
- ldr_wdata  input  DATA_W  loader write data.
- ldr_rdata  output  DATA_W  read data, valid while ldr_ack = 1.
- ldr_ack  output  1  one-cycle completion pulse.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en (synchronous read).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FSM = IDLE.
  - All outputs 0, including registered rdata.
  - last_owner = LDR, so the CPU wins the first tie.
  - burst_cnt = 0.
- FSM IDLE:
  - If no request, stay.
  - Otherwise pick the winner, latch its we/addr/wdata and owner into internal registers, then go to ISSUE.
- FSM ISSUE:
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the latched registers.
  - The write commits at the end of this cycle.
  - Go to DONE.
- FSM DONE:
  - Owner's ack = 1 for this cycle only.
  - Owner's rdata = mem_rdata (registered, held until the next ack for that port). For writes, rdata is unchanged.
  - Update last_owner; go to IDLE.
- Latency: request seen in IDLE at cycle t → mem_en at t+1 → ack at t+2. Back-to-back accesses from one port: one access per 3 cycles.
- Outputs outside ISSUE: mem_en, mem_we, mem_addr and mem_wdata are 0.
- Winner selection in IDLE:
  - Only one req → that port.
  - Both req → the port not equal to last_owner (round-robin).
  - Exception: last_owner = LDR, ldr_lock = 1 and burst_cnt < MAX_BURST → loader wins again.
- burst_cnt:
  - Increments on each loader grant made while cpu_req = 1.
  - Clears on any CPU grant, and in IDLE when ldr_lock = 0.
  - Saturates at MAX_BURST, which forces the next tie to the CPU.
- A latched access always completes, even if the requester drops req mid-access. The requester must hold req/addr/wdata until ack; dropping early is a protocol error, not checked.
- A requester may keep req high after ack to queue its next access; it is re-arbitrated in the following IDLE cycle.
- Reset asserted in ISSUE or DONE: the access is abandoned with no ack. A write in ISSUE may or may not commit at memory.
- cpu_stall is low when cpu_req = 0, including during reset.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs cpu_grant_cnt[15:0] and ldr_grant_cnt[15:0].
  - Each increments on entry to ISSUE for its port and wraps at 16'hFFFF → 0.
  - Adds input stats_clr (1 bit); a synchronous clear to 0 that takes priority over an increment in the same cycle.
  - Both counters reset to 0.
- Undefined: none of these ports or counters exist; arbitration and timing are identical.

Test Plan:
- CPU-only read: CPU read, address 8'h10, memory word 32'hDEADBEEF → mem_en at t+1, cpu_ack and cpu_rdata = 32'hDEADBEEF at t+2; cpu_stall high during t..t+1.
- Loader write then CPU read-back: loader writes 32'h00A5A5A5 to 8'h20, then CPU reads 8'h20 → mem_we = 1 only in the loader ISSUE cycle; cpu_rdata = 32'h00A5A5A5.
- Simultaneous requests, ldr_lock = 0, held for 6 accesses → grant order after reset CPU, LDR, CPU, LDR, CPU, LDR.
- ldr_lock = 1, MAX_BURST = 4, both requesting continuously → LDR×4, CPU, LDR×4, CPU; no CPU starvation beyond 4 loader accesses.
- rst pulsed low during DONE of a CPU read → cpu_ack stays 0, all outputs 0 asynchronously; after release the next simultaneous request grants the CPU first.
- ARB_STATS_EN: 3 CPU and 2 loader accesses → cpu_grant_cnt = 3, ldr_grant_cnt = 2; stats_clr in the same cycle as an increment → counter reads 0.
